// File: rtl/ins_fetch.sv
// Instruction fetch unit: owns the PC, reads a synchronous ROM and hands
// one- or two-word instructions to the decoder. Optional macro: FETCH_CNT_EN.
module ins_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_addr,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_word,
    output logic [DATA_W-1:0] ins_ext,
    output logic              ins_two_word,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [15:0]       fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WORD1,
        S_ADDR2,
        S_WORD2,
        S_OUT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_ext;
    logic              r_two;
    logic [ADDR_W-1:0] r_ipc;

    logic              w_hs;
    logic              w_two;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_hs     = r_valid & ins_ready;
    assign w_two    = (rom_data[DATA_W-1:DATA_W-2] == 2'b10);
    assign w_pc_inc = r_pc + ADDR_W'(1);

    assign rom_addr     = r_pc;
    assign ins_valid    = r_valid;
    assign ins_word     = r_word;
    assign ins_ext      = r_ext;
    assign ins_two_word = r_two;
    assign ins_pc       = r_ipc;

    // Fetch sequencer: PC, capture registers and registered valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_word  <= '0;
            r_ext   <= '0;
            r_two   <= 1'b0;
            r_ipc   <= '0;
        end else if (pc_load) begin
            // A jump discards whatever was in flight.
            r_pc    <= pc_load_addr;
            r_valid <= 1'b0;
            r_state <= en ? S_ADDR : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (en) r_state <= S_ADDR;
                end
                S_ADDR: begin
                    r_state <= S_WORD1;
                end
                S_WORD1: begin
                    r_word <= rom_data;
                    r_ipc  <= r_pc;
                    r_pc   <= w_pc_inc;
                    if (w_two) begin
                        r_state <= S_ADDR2;
                    end else begin
                        r_ext   <= '0;
                        r_two   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_OUT;
                    end
                end
                S_ADDR2: begin
                    r_state <= S_WORD2;
                end
                S_WORD2: begin
                    r_ext   <= rom_data;
                    r_two   <= 1'b1;
                    r_pc    <= w_pc_inc;
                    r_valid <= 1'b1;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    // The ROM samples the next PC on the accepting edge.
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_state <= en ? S_WORD1 : S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] r_fcnt;

    // Saturating count of accepted instructions; jumps do not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (w_hs && (r_fcnt != 16'hFFFF)) begin
            r_fcnt <= r_fcnt + 16'd1;
        end
    end

    assign fetch_count = r_fcnt;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule
